// File: rtl/csa_final_adder_pkg.sv
// Shared constants and FSM encoding for the iterative carry-propagate final adder.
package csa_pkg;

  localparam int CSA_WIDTH  = 128;
  localparam int CSA_CHUNK  = 32;
  localparam int CSA_NCHUNK = CSA_WIDTH / CSA_CHUNK;
  localparam int CSA_IDX_W  = $clog2(CSA_NCHUNK);

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_ADD  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Index width that stays legal when there is only a single chunk.
  function automatic int idx_width(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/csa_final_adder_cpa_chunk_adder.sv
// Combinational CHUNK-bit adder with carry in/out, shared across all chunk iterations.
module cpa_chunk_adder #(
  parameter int CHUNK = 32
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  logic [CHUNK:0] total;

  always_comb begin
    total = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    s     = total[CHUNK-1:0];
    cout  = total[CHUNK];
  end

endmodule

// File: rtl/csa_final_adder.sv
// Resolves the CSA (sum, carry) pair into a binary result, one CHUNK per cycle.
// Optional early termination on all-zero upper bits: define CSA_FINAL_ADD_EARLY_EXIT_EN.
module csa_final_adder
  import csa_pkg::*;
#(
  parameter int WIDTH = CSA_WIDTH,
  parameter int CHUNK = CSA_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] sum_vec,
  input  logic [WIDTH-1:0] carry_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = idx_width(NCHUNK);

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("csa_final_adder: WIDTH must be a multiple of CHUNK");
  end

  state_t           state_q,  state_d;
  logic [IDX_W-1:0] idx_q,    idx_d;
  logic             carry_q,  carry_d;
  logic [WIDTH-1:0] a_q,      a_d;
  logic [WIDTH-1:0] b_q,      b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q,   cout_d;

  int               chunk_base;
  logic [CHUNK-1:0] chunk_a;
  logic [CHUNK-1:0] chunk_b;
  logic [CHUNK-1:0] chunk_s;
  logic             chunk_c;
  logic             last_chunk;

  always_comb begin
    chunk_base = int'(idx_q) * CHUNK;
    chunk_a    = a_q[chunk_base +: CHUNK];
    chunk_b    = b_q[chunk_base +: CHUNK];
    last_chunk = (idx_q == IDX_W'(NCHUNK - 1));
  end

  cpa_chunk_adder #(
    .CHUNK (CHUNK)
  ) u_chunk_adder (
    .a    (chunk_a),
    .b    (chunk_b),
    .cin  (carry_q),
    .s    (chunk_s),
    .cout (chunk_c)
  );

`ifdef CSA_FINAL_ADD_EARLY_EXIT_EN
  logic [WIDTH-1:0] upper_bits;
  logic             upper_zero;

  // Bits above the chunk being added this cycle; a shift past WIDTH yields zero.
  always_comb begin
    upper_bits = (a_q | b_q) >> ((int'(idx_q) + 1) * CHUNK);
    upper_zero = (upper_bits == '0);
  end
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    cout_d   = cout_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = sum_vec;
          b_d     = carry_vec;
          carry_d = 1'b0;
          idx_d   = '0;
          state_d = ST_ADD;
        end
      end

      ST_ADD: begin
        result_d[chunk_base +: CHUNK] = chunk_s;
        carry_d = chunk_c;
        idx_d   = idx_q + IDX_W'(1);
        if (last_chunk) begin
          cout_d  = chunk_c;
          idx_d   = '0;
          state_d = ST_DONE;
        end
`ifdef CSA_FINAL_ADD_EARLY_EXIT_EN
        else if (!chunk_c && upper_zero) begin
          for (int j = 0; j < NCHUNK; j++) begin
            if (j > int'(idx_q)) begin
              result_d[j*CHUNK +: CHUNK] = '0;
            end
          end
          cout_d  = 1'b0;
          idx_d   = '0;
          state_d = ST_DONE;
        end
`endif
      end

      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
    end
  end

  // Operand latches are only meaningful once accepted, so they carry no reset.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_ADD);
  assign result    = result_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_csa_final_adder.sv
// Directed-vector bench for csa_final_adder (128-bit, 32-bit chunks).
module tb_csa_final_adder;

  localparam int W = 128;

`ifdef CSA_FINAL_ADD_EARLY_EXIT_EN
  localparam int LAT_SMALL = 1;
`else
  localparam int LAT_SMALL = 4;
`endif
  localparam int LAT_FULL = 4;
  localparam int TIMEOUT  = 20;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] sum_vec = '0;
  logic [W-1:0] carry_vec = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         cout;
  logic         busy;

  int tests_run    = 0;
  int tests_failed = 0;

  csa_final_adder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum_vec   (sum_vec),
    .carry_vec (carry_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Drives one pair through accept, waits (bounded) for out_valid, captures outputs,
  // then completes the output handshake so the DUT is back in IDLE.
  task automatic run_op(input logic [W-1:0] s, input logic [W-1:0] c,
                        output logic [W-1:0] r, output logic co,
                        output int lat, output int busy_cnt);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    sum_vec   = s;
    carry_vec = c;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat      = 0;
    busy_cnt = busy ? 1 : 0;
    while (!out_valid && lat < TIMEOUT) begin
      @(negedge clk);
      lat++;
      if (busy) busy_cnt++;
    end
    r  = result;
    co = cout;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", busy); end
    tests_run++;
    if (result !== '0) begin tests_failed++; $display("FAIL reset_result got %h want 0", result); end
    tests_run++;
    if (cout !== 1'b0) begin tests_failed++; $display("FAIL reset_cout got %b want 0", cout); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [W-1:0] r; logic co; int lat, bc;
    run_op(128'd120154, 128'd162134, r, co, lat, bc);
    tests_run++;
    if (lat !== LAT_SMALL) begin tests_failed++; $display("FAIL basic_latency got %0d want %0d", lat, LAT_SMALL); end
    tests_run++;
    if (r !== 128'd282288) begin tests_failed++; $display("FAIL basic_result got %0d want 282288", r); end
    tests_run++;
    if (co !== 1'b0) begin tests_failed++; $display("FAIL basic_cout got %b want 0", co); end
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL basic_return_idle got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_all_ones_plus_one();
    logic [W-1:0] r; logic co; int lat, bc;
    run_op({W{1'b1}}, 128'd1, r, co, lat, bc);
    tests_run++;
    if (lat !== LAT_FULL) begin tests_failed++; $display("FAIL wrap_latency got %0d want %0d", lat, LAT_FULL); end
    tests_run++;
    if (bc !== LAT_FULL) begin tests_failed++; $display("FAIL wrap_busy_cycles got %0d want %0d", bc, LAT_FULL); end
    tests_run++;
    if (r !== '0) begin tests_failed++; $display("FAIL wrap_result got %h want 0", r); end
    tests_run++;
    if (co !== 1'b1) begin tests_failed++; $display("FAIL wrap_cout got %b want 1", co); end
  endtask

  task automatic test_max_plus_max();
    logic [W-1:0] r; logic co; int lat, bc;
    run_op({W{1'b1}}, {W{1'b1}}, r, co, lat, bc);
    tests_run++;
    if (r !== 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE) begin
      tests_failed++; $display("FAIL maxmax_result got %h want fff...ffe", r);
    end
    tests_run++;
    if (co !== 1'b1) begin tests_failed++; $display("FAIL maxmax_cout got %b want 1", co); end
    tests_run++;
    if (lat !== LAT_FULL) begin tests_failed++; $display("FAIL maxmax_latency got %0d want %0d", lat, LAT_FULL); end
  endtask

  task automatic test_small_operands();
    logic [W-1:0] r; logic co; int lat, bc;
    run_op(128'd5, 128'd7, r, co, lat, bc);
    tests_run++;
    if (lat !== LAT_SMALL) begin tests_failed++; $display("FAIL small_latency got %0d want %0d", lat, LAT_SMALL); end
    tests_run++;
    if (r !== 128'd12) begin tests_failed++; $display("FAIL small_result got %0d want 12", r); end
    tests_run++;
    if (co !== 1'b0) begin tests_failed++; $display("FAIL small_cout got %b want 0", co); end
    run_op('0, '0, r, co, lat, bc);
    tests_run++;
    if (r !== '0 || co !== 1'b0) begin tests_failed++; $display("FAIL zero_sum got %h/%b want 0/0", r, co); end
    tests_run++;
    if (lat !== LAT_SMALL) begin tests_failed++; $display("FAIL zero_latency got %0d want %0d", lat, LAT_SMALL); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a_res;
    int lat;
    a_res = 128'h0000_0000_0000_0001_0000_0000_FFFF_FFFF;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    sum_vec   = 128'h0000_0000_0000_0001_0000_0000_0000_0000;
    carry_vec = 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < TIMEOUT) begin
      @(negedge clk);
      lat++;
    end
    tests_run++;
    if (!out_valid) begin tests_failed++; $display("FAIL bp_out_valid_timeout got 0 want 1"); end
    // Second pair presented and held during the stall.
    in_valid  = 1'b1;
    sum_vec   = 128'h8000_0000_0000_0000_0000_0000_0000_0000;
    carry_vec = 128'h8000_0000_0000_0000_0000_0000_0000_0000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        tests_failed++; $display("FAIL bp_stall_ctrl cyc %0d got out_valid=%b in_ready=%b want 1/0", i, out_valid, in_ready);
      end
      tests_run++;
      if (result !== a_res || cout !== 1'b0) begin
        tests_failed++; $display("FAIL bp_stall_hold cyc %0d got %h/%b want %h/0", i, result, cout, a_res);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL bp_release got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    tests_run++;
    if (busy !== 1'b1) begin tests_failed++; $display("FAIL bp_second_accept got busy=%b want 1", busy); end
    lat = 0;
    while (!out_valid && lat < TIMEOUT) begin
      @(negedge clk);
      lat++;
    end
    tests_run++;
    if (result !== '0 || cout !== 1'b1) begin
      tests_failed++; $display("FAIL bp_second_result got %h/%b want 0/1", result, cout);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    sum_vec   = {W{1'b1}};
    carry_vec = 128'd1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL midrst_ctrl got in_ready=%b out_valid=%b busy=%b want 1/0/0", in_ready, out_valid, busy);
    end
    tests_run++;
    if (result !== '0 || cout !== 1'b0) begin
      tests_failed++; $display("FAIL midrst_data got %h/%b want 0/0", result, cout);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL midrst_stale cyc %0d got out_valid=%b want 0", i, out_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_all_ones_plus_one();
    test_max_plus_max();
    test_backpressure();
    test_reset_mid();
    test_small_operands();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
